// File: rtl/npu_matrix_ram_writer.sv
// Write-back engine: snapshots an N x N signed result matrix on start and streams it
// row-major into data RAM over a single-port write bus with ready backpressure.
module npu_matrix_ram_writer #(
   parameter int N      = 10,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic [ADDR_W-1:0]                       base_addr,
   input  logic signed [N-1:0][N-1:0][DATA_W-1:0]  in_matrix,
   output logic [ADDR_W-1:0]                       mem_addr,
   output logic [DATA_W-1:0]                       mem_wdata,
   output logic                                    mem_we,
   input  logic                                    mem_ready,
   output logic                                    busy,
   output logic                                    done
);

   localparam int RC_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [RC_W-1:0] LAST_IDX = RC_W'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                          state_r, state_s;
   logic [RC_W-1:0]                 row_r, row_s;
   logic [RC_W-1:0]                 col_r, col_s;
   logic [ADDR_W-1:0]               addr_s;
   logic [DATA_W-1:0]               wdata_s;
   logic                            we_s;
   logic                            busy_s;
   logic                            done_s;
   logic                            snap_load_s;
   logic [N-1:0][N-1:0][DATA_W-1:0] snap_r;

   // Next-state and next-output logic; the address advances by one per accepted beat,
   // which equals base + row*N + col modulo 2^ADDR_W without a multiplier.
   always_comb begin
      state_s     = state_r;
      row_s       = row_r;
      col_s       = col_r;
      addr_s      = mem_addr;
      wdata_s     = mem_wdata;
      we_s        = mem_we;
      busy_s      = busy;
      done_s      = 1'b0;
      snap_load_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               snap_load_s = 1'b1;
               row_s       = {RC_W{1'b0}};
               col_s       = {RC_W{1'b0}};
               addr_s      = base_addr;
               wdata_s     = in_matrix[0][0];
               we_s        = 1'b1;
               busy_s      = 1'b1;
               state_s     = ST_WRITE;
            end else begin
               we_s   = 1'b0;
               busy_s = 1'b0;
            end
         end
         ST_WRITE: begin
            if (mem_we && mem_ready) begin
               if (col_r != LAST_IDX) begin
                  col_s   = col_r + RC_W'(1);
                  addr_s  = mem_addr + ADDR_W'(1);
                  wdata_s = snap_r[row_r][col_s];
               end else if (row_r != LAST_IDX) begin
                  col_s   = {RC_W{1'b0}};
                  row_s   = row_r + RC_W'(1);
                  addr_s  = mem_addr + ADDR_W'(1);
                  wdata_s = snap_r[row_s][col_s];
               end else begin
                  we_s    = 1'b0;
                  done_s  = 1'b1;
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_DONE: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            we_s    = 1'b0;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered bus outputs; reset abandons any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         row_r     <= {RC_W{1'b0}};
         col_r     <= {RC_W{1'b0}};
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_s;
         row_r     <= row_s;
         col_r     <= col_s;
         mem_addr  <= addr_s;
         mem_wdata <= wdata_s;
         mem_we    <= we_s;
         busy      <= busy_s;
         done      <= done_s;
      end
   end

   // Matrix snapshot taken with an accepted start; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (snap_load_s) begin
         snap_r <= in_matrix;
      end
   end

endmodule

// File: tb/tb_npu_matrix_ram_writer.sv
// Directed bench for npu_matrix_ram_writer: a scoreboard of expected (addr, data) beats
// is filled at each start and drained as the RAM accepts writes.
module tb_npu_matrix_ram_writer;

   localparam int N  = 10;
   localparam int DW = 16;
   localparam int AW = 16;

   typedef logic signed [N-1:0][N-1:0][DW-1:0] mat_t;
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   mat_t          in_matrix;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_ready;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   npu_matrix_ram_writer #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_matrix (in_matrix),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done)
   );

   beat_t         sb[$];
   int            passed = 0;
   int            total = 0;
   int            edge_n = 0;
   int            acc_cnt = 0;
   int            done_cnt = 0;
   int            busy_cnt = 0;
   int            last_acc_edge = -1;
   bit            rnd_ready = 1'b0;
   bit            hold_pend = 1'b0;
   logic [AW-1:0] prev_a;
   logic [DW-1:0] prev_d;
   mat_t          mat_a, mat_w, mat_f;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push_matrix(input logic [AW-1:0] base, input mat_t m);
      for (int k = 0; k < N * N; k++) begin
         beat_t b;
         b.a = base + AW'(k);
         b.d = m[k / N][k % N];
         sb.push_back(b);
      end
   endtask

   task automatic reset_stats();
      acc_cnt       = 0;
      done_cnt      = 0;
      busy_cnt      = 0;
      last_acc_edge = -1;
   endtask

   // One clock: observe 1 time unit after the rising edge, drive mem_ready for the next edge.
   task automatic step();
      beat_t e;
      @(posedge clk);
      #1;
      edge_n++;
      mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_pend) begin
         check("hold_addr", 32'(mem_addr), 32'(prev_a));
         check("hold_data", 32'(mem_wdata), 32'(prev_d));
      end
      if (mem_we && mem_ready) begin
         if (sb.size() == 0) begin
            check("extra_write", 32'(mem_we), 32'd0);
         end else begin
            e = sb.pop_front();
            check("addr", 32'(mem_addr), 32'(e.a));
            check("data", 32'(mem_wdata), 32'(e.d));
            acc_cnt++;
            if (sb.size() == 0) last_acc_edge = edge_n + 1;
         end
      end
      hold_pend = mem_we && !mem_ready;
      prev_a    = mem_addr;
      prev_d    = mem_wdata;
      if (done) begin
         done_cnt++;
         check("done_after_last", 32'(edge_n), 32'(last_acc_edge));
         check("sb_empty_at_done", 32'(sb.size()), 32'd0);
      end
      if (busy) busy_cnt++;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) step();
      check("done_seen", 32'(done_cnt), 32'(d0 + 1));
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input mat_t m);
      start     = 1'b1;
      base_addr = base;
      in_matrix = m;
      push_matrix(base, m);
      step();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("we_after_start", 32'(mem_we), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      in_matrix = '0;
      mem_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = DW'(i + j);
            mat_w[i][j] = DW'(-(i * N + j));
            mat_f[i][j] = 16'h7FFF;
         end
      end
      #12;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: full-speed transfer of i+j at 0x0100
      reset_stats();
      rnd_ready = 1'b0;
      step();
      start_xfer(16'h0100, mat_a);
      wait_done(200);
      step();
      check("t1_busy_cycles", 32'(busy_cnt), 32'd101);
      check("t1_writes", 32'(acc_cnt), 32'd100);
      check("t1_done_pulses", 32'(done_cnt), 32'd1);

      // 2: random backpressure
      reset_stats();
      rnd_ready = 1'b1;
      start_xfer(16'h0100, mat_a);
      wait_done(2000);
      repeat (6) begin
         step();
         check("t2_no_we_after", 32'(mem_we), 32'd0);
      end
      check("t2_writes", 32'(acc_cnt), 32'd100);
      check("t2_done_pulses", 32'(done_cnt), 32'd1);

      // 3: snapshot isolation and start while busy
      reset_stats();
      rnd_ready = 1'b0;
      start_xfer(16'h0100, mat_a);
      in_matrix = mat_f;
      base_addr = 16'h0000;
      repeat (4) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(200);
      repeat (6) begin
         step();
         check("t3_idle_busy", 32'(busy), 32'd0);
      end
      check("t3_writes", 32'(acc_cnt), 32'd100);
      check("t3_done_pulses", 32'(done_cnt), 32'd1);

      // 4: address wrap with negative data
      reset_stats();
      start_xfer(16'hFFF0, mat_w);
      wait_done(200);
      check("t4_writes", 32'(acc_cnt), 32'd100);

      // 5: asynchronous reset mid-transfer
      step();
      reset_stats();
      start_xfer(16'h0100, mat_a);
      for (int i = 0; i < 200 && acc_cnt < 37; i++) step();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t5_rst_we", 32'(mem_we), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      sb.delete();
      hold_pend = 1'b0;
      #10;
      @(negedge clk);
      rst = 1'b0;
      rnd_ready = 1'b1;
      repeat (20) begin
         step();
         check("t5_idle_we", 32'(mem_we), 32'd0);
      end
      rnd_ready = 1'b0;
      reset_stats();
      start_xfer(16'h0100, mat_a);
      wait_done(200);
      check("t5_writes", 32'(acc_cnt), 32'd100);

      // 6: back-to-back start on the cycle after done
      step();
      reset_stats();
      start_xfer(16'h0200, mat_a);
      wait_done(200);
      step();
      start_xfer(16'h0300, mat_w);
      wait_done(200);
      repeat (4) step();
      check("t6_writes", 32'(acc_cnt), 32'd200);
      check("t6_done_pulses", 32'(done_cnt), 32'd2);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/npu_matrix_ram_writer.md
Name: npu_matrix_ram_writer

Overview:
Write-back engine of the NPU datapath. It snapshots a finished N x N signed 16-bit result matrix (post systolic/Leaky ReLU/normalization) on a start pulse. It then streams the elements row-major into the result region of the data RAM over a single-port write bus with ready backpressure. It is the store-side counterpart of the matrix load path that fills the NPU input matrix from RAM.

Parameters:
N, 10, matrix dimension (rows = cols = N)
DATA_W, 16, element width, two's complement
ADDR_W, 16, RAM word-address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to write the matrix; sampled only in IDLE
base_addr  input  ADDR_W  RAM word address of element [0][0]; sampled with start
in_matrix  input  N x N x DATA_W signed  result matrix; sampled with start
mem_addr  output  ADDR_W  write word address
mem_wdata  output  DATA_W  write data
mem_we  output  1  write request; held until accepted
mem_ready  input  1  RAM accepts the write when mem_we && mem_ready at a rising edge
busy  output  1  high from the cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse after the last write is accepted

Behaviour:
- Reset (async assert, any state): state=IDLE, row=col=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. Snapshot contents don't care. A write in flight is abandoned, with no further mem_we.
- FSM states: IDLE, WRITE, DONE.
- IDLE: on start=1, copy in_matrix to the internal snapshot, latch base_addr, set row=col=0, go to WRITE. Subsequent in_matrix/base_addr changes have no effect on the transfer.
- WRITE: mem_we=1, mem_wdata=snap[row][col], mem_addr=(base+row*N+col) mod 2^ADDR_W. All are registered outputs, stable while mem_we && !mem_ready.
- On an accepted beat (mem_we && mem_ready):
  - If col<N-1: col++.
  - Else if row<N-1: col=0, row++.
  - Else: mem_we=0, go to DONE.
  - The next beat's addr/data are presented in the following cycle with no bubble, so one element per cycle when mem_ready=1.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
- Latency, with the accepted start at edge 0 and mem_ready tied high:
  - first mem_we visible after edge 0;
  - the N*N-th write is accepted at edge N*N;
  - done is high during the cycle after edge N*N;
  - the next start is accepted at the earliest one cycle after done.
- Start while busy (WRITE or DONE) is ignored, with no queueing.
- Address arithmetic: row*N+col is computed at ADDR_W width; the sum with base wraps modulo 2^ADDR_W, with no error flag.
- mem_ready is don't care when mem_we=0.
- Data is passed through unchanged (no saturation or truncation; DATA_W in equals DATA_W out).
- Exactly N*N writes per start, each address written once, strictly ascending modulo wrap.

Test Plan:
1. in_matrix[i][j]=i+j, base_addr=0x0100, start, mem_ready=1 -> 100 consecutive writes:
   - addr 0x0100..0x0163 with data[k]=k/10+k%10 (e.g. addr 0x010B data 2);
   - done is high exactly at the cycle after the 100th accepted write;
   - busy is high for 101 cycles.
2. Same matrix with mem_ready toggling 1,0,0,1,… (pseudo-random) -> addr/data held stable while stalled, no dropped or duplicated element, done only after the 100th acceptance, no mem_we afterward.
3. Snapshot and start-while-busy: start, then change in_matrix to all 0x7FFF, base_addr to 0x0000, and pulse start again in the 5th write cycle:
   - RAM holds the original i+j values at 0x0100..0x0163 only;
   - the second start is ignored;
   - a single done pulse.
4. Address wrap with base_addr=0xFFF0 and element [i][j]=-(i*10+j):
   - writes cover 0xFFF0..0xFFFF then 0x0000..0x0053;
   - addr 0x0000 carries data -16 (0xFFF0).
5. Reset mid-operation: assert rst asynchronously after the 37th accepted write (between edges) -> mem_we, busy and done drop immediately. After release, with no start: idle with mem_we=0 indefinitely. A new start then produces a full 100-write sequence from element [0][0].
6. Back-to-back: start on the cycle after done -> accepted; a second complete 100-write transfer; done pulses exactly twice in total.
